// File: rtl/gf22_sram64_rd_stream_if.sv
// Burst request and output stream bundle for the SRAM read streamer.
// slave is the streamer side, master is the requester/consumer side.
interface gf22_sram64_rd_stream_if #(
  parameter int ABITS = 15,
  parameter int DW    = 64
);
  logic             req_valid;
  logic             req_ready;
  logic [ABITS-1:0] req_addr;
  logic [ABITS:0]   req_len;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_last;

  modport master (
    output req_valid, req_addr, req_len, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  req_valid, req_addr, req_len, out_ready,
    output req_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/gf22_sram64_rd_stream.sv
// Streams a burst of SRAM words (1-cycle read latency) into a credit-limited
// first-word-fall-through FIFO that feeds a valid/ready output stream.
module gf22_sram64_rd_stream #(
  parameter int ABITS = 15,
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  gf22_sram64_rd_stream_if.slave    bus,
  output logic                      CE1,
  output logic [ABITS-1:0]          A1,
  input  logic [DW-1:0]             Q1,
  output logic                      busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [ABITS:0] ONE     = (ABITS+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state, state_nx;
  logic [ABITS-1:0] addr_q, a1_q;
  logic [ABITS:0]   len_q, issued, popped;
  logic             inflight;
  logic [DW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             accept, ce, last_issue, push, pop;

  // Credit counts the read still in the SRAM pipe so the FIFO can never overflow.
  always_comb begin
    accept     = (state == IDLE) && bus.req_valid;
    ce         = (state == ISSUE) && (issued < len_q) &&
                 ((count + CW'(inflight)) < DEPTH_C);
    last_issue = ce && (issued == len_q - ONE);
    push       = inflight;
    pop        = bus.out_valid && bus.out_ready;
  end

  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign CE1           = ce;
  assign A1            = ce ? (addr_q + issued[ABITS-1:0]) : a1_q;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rptr];
  assign bus.out_last  = bus.out_valid && (popped == len_q - ONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && (bus.req_len != '0)) state_nx = ISSUE;
      ISSUE:   if (last_issue) state_nx = DRAIN;
      DRAIN:   if (pop && bus.out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      addr_q   <= '0;
      a1_q     <= '0;
      len_q    <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      inflight <= ce;
      if (accept) begin
        addr_q <= bus.req_addr;
        len_q  <= bus.req_len;
        issued <= '0;
        popped <= '0;
      end
      if (ce) begin
        issued <= issued + ONE;
        a1_q   <= A1;
      end
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr   <= rptr + PW'(1);
        popped <= popped + ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= Q1;
  end
endmodule

// File: tb/tb_gf22_sram64_rd_stream.sv
// Directed + randomized bench: SRAM data model, stream scoreboard, protocol checks.
module tb_gf22_sram64_rd_stream;
  localparam int ABITS = 15;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic             CE1;
  logic [ABITS-1:0] A1;
  logic [DW-1:0]    Q1;
  logic             busy;

  gf22_sram64_rd_stream_if #(.ABITS(ABITS), .DW(DW)) bus ();

  gf22_sram64_rd_stream #(.ABITS(ABITS), .DW(DW), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus),
    .CE1 (CE1),
    .A1  (A1),
    .Q1  (Q1),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] salt;

  logic [ABITS-1:0] ce_q[$];
  int               ce_cyc[$];
  logic [DW-1:0]    beat_q[$];
  logic             last_q[$];
  int               beat_cyc[$];
  int               acc_cyc;
  int               ce_tot, pop_tot, occ_max;
  logic             stall_q = 1'b0;
  logic [DW-1:0]    stall_data;

  function automatic logic [DW-1:0] word(input logic [ABITS-1:0] a);
    return {salt ^ (32'(a) * 32'h9E3779B1), 17'h0, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SRAM model: data for the address presented with CE1 appears the next cycle.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    Q1  <= CE1 ? word(A1) : {$urandom, $urandom};
  end

  always @(negedge CLK) begin
    if (RSTN) begin
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      if (CE1) begin
        ce_q.push_back(A1);
        ce_cyc.push_back(cyc);
        ce_tot++;
      end
      if (ce_tot - pop_tot > occ_max) occ_max = ce_tot - pop_tot;
      if (stall_q) begin
        check("hold_valid", 64'(bus.out_valid), 64'(1));
        check("hold_data", bus.out_data, stall_data);
      end
      stall_q    = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        beat_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        beat_cyc.push_back(cyc);
        pop_tot++;
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic clear_logs();
    ce_q.delete(); ce_cyc.delete(); beat_q.delete(); last_q.delete(); beat_cyc.delete();
    ce_tot = 0; pop_tot = 0; occ_max = 0; acc_cyc = -1;
  endtask

  task automatic start_req(input logic [ABITS-1:0] addr, input int len, input logic rdy);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = (ABITS+1)'(len);
    bus.out_ready = rdy;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_burst(input int len, input int mode, input int budget);
    int n = 0;
    while (!(beat_q.size() == len && !busy) && n < budget) begin
      bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge CLK); #1;
      n++;
    end
    check("burst_done", 64'(beat_q.size() == len && !busy), 64'(1));
  endtask

  task automatic verify(input string tag, input logic [ABITS-1:0] addr, input int len);
    check({tag, "_nreads"}, 64'(ce_q.size()), 64'(len));
    check({tag, "_nbeats"}, 64'(beat_q.size()), 64'(len));
    for (int i = 0; i < len && i < ce_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), 64'(ce_q[i]), 64'(ABITS'(addr + i)));
    for (int i = 0; i < len && i < beat_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), beat_q[i], word(ABITS'(addr + i)));
      check($sformatf("%s_last%0d", tag, i), 64'(last_q[i]), 64'(i == len - 1));
    end
    check({tag, "_occupancy_le_depth"}, 64'(occ_max <= DEPTH), 64'(1));
  endtask

  initial begin
    int n, last_beat;
    logic [ABITS-1:0] raddr;
    salt          = $urandom;
    RSTN          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b0;
    clear_logs();

    #12;
    check("rst_ce1", 64'(CE1), 64'(0));
    check("rst_a1", 64'(A1), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    @(negedge CLK); RSTN = 1'b1;
    @(posedge CLK); #1;

    // Basic burst, consumer always ready: timing and throughput.
    clear_logs();
    start_req(15'h0010, 3, 1'b1);
    finish_burst(3, 0, 50);
    verify("b3", 15'h0010, 3);
    if (ce_cyc.size() == 3 && beat_cyc.size() == 3) begin
      check("b3_first_ce_lat", 64'(ce_cyc[0] - acc_cyc), 64'(1));
      check("b3_first_beat_lat", 64'(beat_cyc[0] - ce_cyc[0]), 64'(2));
      for (int i = 1; i < 3; i++) begin
        check($sformatf("b3_ce_gap%0d", i), 64'(ce_cyc[i] - ce_cyc[i-1]), 64'(1));
        check($sformatf("b3_beat_gap%0d", i), 64'(beat_cyc[i] - beat_cyc[i-1]), 64'(1));
      end
    end
    check("b3_busy_after", 64'(busy), 64'(0));

    // Address wrap at the top of the SRAM.
    clear_logs();
    start_req(15'h7FFE, 4, 1'b1);
    finish_burst(4, 0, 50);
    verify("wrap", 15'h7FFE, 4);

    // Zero-length request.
    clear_logs();
    start_req(15'h0055, 0, 1'b1);
    check("len0_busy", 64'(busy), 64'(0));
    check("len0_req_ready", 64'(bus.req_ready), 64'(1));
    check("len0_ce1", 64'(CE1), 64'(0));
    repeat (4) begin @(posedge CLK); #1; end
    check("len0_nreads", 64'(ce_q.size()), 64'(0));
    check("len0_nbeats", 64'(beat_q.size()), 64'(0));

    // Back-pressure: credits stop the read port at FIFO depth.
    clear_logs();
    start_req(15'h0400, 16, 1'b0);
    repeat (12) begin @(posedge CLK); #1; end
    check("bp_nreads", 64'(ce_q.size()), 64'(DEPTH));
    check("bp_ce1_idle", 64'(CE1), 64'(0));
    check("bp_out_valid", 64'(bus.out_valid), 64'(1));
    check("bp_head", bus.out_data, word(15'h0400));
    check("bp_req_ready", 64'(bus.req_ready), 64'(0));
    repeat (3) begin @(posedge CLK); #1; end
    check("bp_nreads_later", 64'(ce_q.size()), 64'(DEPTH));
    check("bp_head_later", bus.out_data, word(15'h0400));
    finish_burst(16, 0, 100);
    verify("bp", 15'h0400, 16);

    // Long burst with random consumer stalls.
    clear_logs();
    raddr = ABITS'($urandom);
    start_req(raddr, 100, 1'($urandom_range(0, 1)));
    finish_burst(100, 1, 2000);
    verify("rnd", raddr, 100);

    // Back-to-back: next request lands the cycle after the final handshake.
    last_beat = (beat_cyc.size() > 0) ? beat_cyc[$] : -100;
    clear_logs();
    start_req(15'h1234, 5, 1'b1);
    check("b2b_accept_gap", 64'(acc_cyc - last_beat), 64'(1));
    finish_burst(5, 0, 50);
    verify("b2b", 15'h1234, 5);

    // Reset in the middle of a burst.
    clear_logs();
    start_req(15'h0100, 8, 1'b1);
    n = 0;
    while (beat_q.size() < 3 && n < 40) begin @(posedge CLK); #1; n++; end
    check("mid_reached_3_beats", 64'(beat_q.size() >= 3), 64'(1));
    #2 RSTN = 1'b0;
    #1;
    check("mid_rst_ce1", 64'(CE1), 64'(0));
    check("mid_rst_a1", 64'(A1), 64'(0));
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_out_last", 64'(bus.out_last), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    @(posedge CLK);
    @(negedge CLK); RSTN = 1'b1;
    @(posedge CLK); #1;
    clear_logs();
    check("post_rst_req_ready", 64'(bus.req_ready), 64'(1));
    start_req(15'h0020, 2, 1'b1);
    finish_burst(2, 0, 50);
    repeat (3) begin @(posedge CLK); #1; end
    verify("post_rst", 15'h0020, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
